// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX register stage: control bundle
// layout, result-select encodings and the bubble value.
package id_ex_stage_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int RES_SRC_W  = 2;
   localparam int ALU_CTRL_W = 3;

   typedef enum logic [RES_SRC_W-1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_write;
      logic                  jump;
      logic                  branch;
      logic                  alu_src;
      logic [RES_SRC_W-1:0]  result_src;
      logic [ALU_CTRL_W-1:0] alu_control;
   } ctrl_t;

   // A bubble must not write anything or redirect the PC.
   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic logic is_load(input logic [RES_SRC_W-1:0] res_src);
      return res_src == RES_LOAD;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, execute-side outputs, hazard controls and event
// counters of the ID/EX stage. The stage itself connects through 'slave'.
interface id_ex_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic [XLEN-1:0]  RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [4:0]       Rs1D, Rs2D, RdD;
   logic             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
   logic [1:0]       ResultSrcD;
   logic [2:0]       ALUControlD;
   logic             PCSrcE;

   logic [XLEN-1:0]  RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]       Rs1E, Rs2E, RdE;
   logic             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
   logic [1:0]       ResultSrcE;
   logic [2:0]       ALUControlE;

   logic             StallF, StallD, FlushD;
   logic [CNT_W-1:0] StallCnt, FlushCnt;

   modport master (
      output RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD,
             ALUControlD, PCSrcE,
      input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE,
             ResultSrcE, ALUControlE, StallF, StallD, FlushD,
             StallCnt, FlushCnt
   );

   modport slave (
      input  RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD,
             ALUControlD, PCSrcE,
      output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE,
             ResultSrcE, ALUControlE, StallF, StallD, FlushD,
             StallCnt, FlushCnt
   );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a valid load in Execute whose destination is
// read by the instruction in Decode. x0 is never a real dependency.
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic [RES_SRC_W-1:0]  result_src_e_i,
   input  logic                  valid_e_i,
   input  logic [REG_ADDR_W-1:0] rd_e_i,
   input  logic [REG_ADDR_W-1:0] rs1_d_i,
   input  logic [REG_ADDR_W-1:0] rs2_d_i,
   output logic                  lw_stall_o
);

   logic rd_nonzero;
   logic src_match;

   // Rs1D==Rs2D==RdE collapses into one match, so it yields a single stall.
   always_comb begin
      rd_nonzero = (rd_e_i != '0);
      src_match  = (rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i);
      lw_stall_o = is_load(result_src_e_i) && valid_e_i && rd_nonzero && src_match;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch flush handling.
// Execute never holds: a hazard is resolved by inserting one bubble while
// fetch and decode are stalled for that cycle.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
)(
   input  logic         clk,
   input  logic         rst,
   id_ex_stage_if.slave bus
);

   logic                  lw_stall;
   logic                  flush_e;

   ctrl_t                 ctrl_d, ctrl_q;
   logic                  valid_d, valid_q;
   logic [REG_ADDR_W-1:0] rd_d, rd_q;
   logic [REG_ADDR_W-1:0] rs1_q, rs2_q;
   logic [XLEN-1:0]       rd1_q, rd2_q, imm_q, pc_q, pc4_q;
   logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0]      flush_cnt_d, flush_cnt_q;

   hazard_detect u_hazard_detect (
      .result_src_e_i (ctrl_q.result_src),
      .valid_e_i      (valid_q),
      .rd_e_i         (rd_q),
      .rs1_d_i        (bus.Rs1D),
      .rs2_d_i        (bus.Rs2D),
      .lw_stall_o     (lw_stall)
   );

   assign flush_e     = lw_stall | bus.PCSrcE;
   assign bus.StallF  = lw_stall;
   assign bus.StallD  = lw_stall;
   assign bus.FlushD  = bus.PCSrcE;

   // Next-state for control/valid/rd: bubble on flush, else the decoded instruction.
   always_comb begin
      ctrl_d      = CTRL_BUBBLE;
      valid_d     = 1'b0;
      rd_d        = '0;
      stall_cnt_d = stall_cnt_q + CNT_W'(lw_stall);
      flush_cnt_d = flush_cnt_q + CNT_W'(bus.PCSrcE);
      if (!flush_e) begin
         ctrl_d.reg_write   = bus.RegWriteD;
         ctrl_d.mem_write   = bus.MemWriteD;
         ctrl_d.jump        = bus.JumpD;
         ctrl_d.branch      = bus.BranchD;
         ctrl_d.alu_src     = bus.ALUSrcD;
         ctrl_d.result_src  = bus.ResultSrcD;
         ctrl_d.alu_control = bus.ALUControlD;
         valid_d            = 1'b1;
         rd_d               = bus.RdD;
      end
   end

   // Pipeline register bank and event counters; reset wins over everything.
   // Datapath fields load unconditionally since a bubble makes them don't-care.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q      <= CTRL_BUBBLE;
         valid_q     <= 1'b0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         pc4_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         rd_q        <= rd_d;
         rs1_q       <= bus.Rs1D;
         rs2_q       <= bus.Rs2D;
         rd1_q       <= bus.RD1D;
         rd2_q       <= bus.RD2D;
         imm_q       <= bus.ImmExtD;
         pc_q        <= bus.PCD;
         pc4_q       <= bus.PCPlus4D;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.RD1E        = rd1_q;
   assign bus.RD2E        = rd2_q;
   assign bus.ImmExtE     = imm_q;
   assign bus.PCE         = pc_q;
   assign bus.PCPlus4E    = pc4_q;
   assign bus.Rs1E        = rs1_q;
   assign bus.Rs2E        = rs2_q;
   assign bus.RdE         = rd_q;
   assign bus.RegWriteE   = ctrl_q.reg_write;
   assign bus.MemWriteE   = ctrl_q.mem_write;
   assign bus.JumpE       = ctrl_q.jump;
   assign bus.BranchE     = ctrl_q.branch;
   assign bus.ALUSrcE     = ctrl_q.alu_src;
   assign bus.ResultSrcE  = ctrl_q.result_src;
   assign bus.ALUControlE = ctrl_q.alu_control;
   assign bus.ValidE      = valid_q;
   assign bus.StallCnt    = stall_cnt_q;
   assign bus.FlushCnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios followed by random
// traffic, all checked against a cycle-level reference model.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit          valid;
      int          rd, rs1, rs2, res, alu;
      bit          rw, mw, j, b, as;
      logic [31:0] rd1, rd2, imm, pc, pc4;
   } e_t;

   e_t m;              // expected Execute-side contents
   bit m_known = 0;    // model valid once the first reset edge is seen
   bit m_dp_known = 0; // datapath fields defined (not a bubble)
   int m_scnt = 0;
   int m_fcnt = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_d(input int rs1, input int rs2, input int rd, input int res,
                        input bit rw, input logic [31:0] rd1);
      bus.Rs1D        = 5'(rs1);
      bus.Rs2D        = 5'(rs2);
      bus.RdD         = 5'(rd);
      bus.ResultSrcD  = 2'(res);
      bus.RegWriteD   = rw;
      bus.RD1D        = rd1;
      bus.RD2D        = $urandom;
      bus.ImmExtD     = $urandom;
      bus.PCD         = $urandom;
      bus.PCPlus4D    = bus.PCD + 32'd4;
      bus.MemWriteD   = 1'($urandom_range(0, 1));
      bus.JumpD       = 1'($urandom_range(0, 1));
      bus.BranchD     = 1'($urandom_range(0, 1));
      bus.ALUSrcD     = 1'($urandom_range(0, 1));
      bus.ALUControlD = 3'($urandom_range(0, 7));
   endtask

   // One clock: check hazard outputs before the edge, advance model, check E side.
   task automatic cycle(input bit pcsrc, input bit rst_v);
      bit st;
      e_t nx;
      bus.PCSrcE = pcsrc;
      rst        = rst_v;
      #2;
      st = (m.res == 1) && m.valid && (m.rd != 0) &&
           (int'(bus.Rs1D) == m.rd || int'(bus.Rs2D) == m.rd);
      if (m_known) begin
         check_eq("StallF", bus.StallF, st);
         check_eq("StallD", bus.StallD, st);
         check_eq("FlushD", bus.FlushD, pcsrc);
      end
      nx.valid = 1;
      nx.rd  = bus.RdD;    nx.rs1 = bus.Rs1D;    nx.rs2 = bus.Rs2D;
      nx.res = bus.ResultSrcD; nx.alu = bus.ALUControlD;
      nx.rw  = bus.RegWriteD; nx.mw = bus.MemWriteD; nx.j = bus.JumpD;
      nx.b   = bus.BranchD;   nx.as = bus.ALUSrcD;
      nx.rd1 = bus.RD1D; nx.rd2 = bus.RD2D; nx.imm = bus.ImmExtD;
      nx.pc  = bus.PCD;  nx.pc4 = bus.PCPlus4D;
      @(posedge clk);
      #1;
      if (rst_v) begin
         m = '{default: 0};
         m_known = 1; m_dp_known = 1; m_scnt = 0; m_fcnt = 0;
      end else begin
         m_scnt = (m_scnt + int'(st)) % CNT_MOD;
         m_fcnt = (m_fcnt + int'(pcsrc)) % CNT_MOD;
         if (st || pcsrc) begin
            m.valid = 0; m.rd = 0; m.res = 0;
            m.rw = 0; m.mw = 0; m.j = 0; m.b = 0;
            m_dp_known = 0;
         end else begin
            m = nx;
            m_dp_known = 1;
         end
      end
      check_eq("ValidE", bus.ValidE, m.valid);
      check_eq("RdE", bus.RdE, m.rd);
      check_eq("ResultSrcE", bus.ResultSrcE, m.res);
      check_eq("RegWriteE", bus.RegWriteE, m.rw);
      check_eq("MemWriteE", bus.MemWriteE, m.mw);
      check_eq("JumpE", bus.JumpE, m.j);
      check_eq("BranchE", bus.BranchE, m.b);
      check_eq("StallCnt", bus.StallCnt, m_scnt);
      check_eq("FlushCnt", bus.FlushCnt, m_fcnt);
      if (m_dp_known) begin
         check_eq("Rs1E", bus.Rs1E, m.rs1);
         check_eq("Rs2E", bus.Rs2E, m.rs2);
         check_eq("ALUSrcE", bus.ALUSrcE, m.as);
         check_eq("ALUControlE", bus.ALUControlE, m.alu);
         check_eq("RD1E", bus.RD1E, m.rd1);
         check_eq("RD2E", bus.RD2E, m.rd2);
         check_eq("ImmExtE", bus.ImmExtE, m.imm);
         check_eq("PCE", bus.PCE, m.pc);
         check_eq("PCPlus4E", bus.PCPlus4E, m.pc4);
      end
   endtask

   initial begin
      int guard;
      m = '{default: 0};
      rst = 1'b1;
      bus.PCSrcE = 1'b1;
      set_d(3, 4, 9, 1, 1, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;

      // reset for two cycles with nonzero inputs
      cycle(1, 1);
      cycle(1, 1);
      check_eq("rst_ValidE", bus.ValidE, 0);
      check_eq("rst_RD1E", bus.RD1E, 0);
      check_eq("rst_StallCnt", bus.StallCnt, 0);
      check_eq("rst_FlushCnt", bus.FlushCnt, 0);

      // ADD x5, then dependent ALU op: no stall
      set_d(1, 2, 5, 0, 1, 32'h1111);
      cycle(0, 0);
      set_d(5, 6, 7, 0, 1, 32'h1234);
      cycle(0, 0);
      check_eq("add_RD1E", bus.RD1E, 32'h1234);
      check_eq("add_RdE", bus.RdE, 7);
      check_eq("add_ValidE", bus.ValidE, 1);

      // lw x5 followed by use on rs2
      set_d(0, 0, 5, 1, 1, 32'h0);
      cycle(0, 0);
      set_d(3, 5, 8, 0, 1, 32'h55);
      #2;
      check_eq("lw_StallF", bus.StallF, 1);
      cycle(0, 0);
      check_eq("lw_bubble_ValidE", bus.ValidE, 0);
      check_eq("lw_bubble_RegWriteE", bus.RegWriteE, 0);
      check_eq("lw_StallCnt", bus.StallCnt, 1);
      cycle(0, 0);
      check_eq("lw_release_ValidE", bus.ValidE, 1);

      // lw x0 followed by read of x0: no stall
      set_d(0, 0, 0, 1, 1, 32'h0);
      cycle(0, 0);
      set_d(0, 0, 4, 0, 1, 32'h77);
      cycle(0, 0);
      check_eq("lwx0_StallCnt", bus.StallCnt, 1);

      // taken branch
      set_d(1, 2, 3, 0, 1, 32'h88);
      cycle(1, 0);
      check_eq("br_ValidE", bus.ValidE, 0);
      check_eq("br_FlushCnt", bus.FlushCnt, 1);

      // load-use with Rs1D==Rs2D==RdE coinciding with branch
      set_d(0, 0, 5, 1, 1, 32'h0);
      cycle(0, 0);
      set_d(5, 5, 6, 0, 1, 32'h99);
      cycle(1, 0);
      check_eq("both_StallCnt", bus.StallCnt, 2);
      check_eq("both_FlushCnt", bus.FlushCnt, 2);
      check_eq("both_ValidE", bus.ValidE, 0);

      // drive StallCnt to 15, then one more wraps to 0
      guard = 0;
      while (m_scnt != 15 && guard < 40) begin
         set_d(0, 0, 5, 1, 1, 32'h0);
         cycle(0, 0);
         set_d(5, 1, 6, 0, 1, 32'h1);
         cycle(0, 0);
         guard++;
      end
      check_eq("pre_wrap_StallCnt", bus.StallCnt, 15);
      set_d(0, 0, 5, 1, 1, 32'h0);
      cycle(0, 0);
      set_d(1, 5, 6, 0, 1, 32'h1);
      cycle(0, 0);
      check_eq("wrap_StallCnt", bus.StallCnt, 0);

      // random traffic biased toward hazards
      for (int i = 0; i < 400; i++) begin
         int rs1, rs2, res;
         rs1 = ($urandom_range(0, 1) == 1) ? m.rd : int'($urandom_range(0, 31));
         rs2 = ($urandom_range(0, 2) == 0) ? m.rd : int'($urandom_range(0, 31));
         res = ($urandom_range(0, 9) < 4) ? 1 : int'($urandom_range(0, 2));
         set_d(rs1, rs2, int'($urandom_range(0, 7)), res, 1'($urandom_range(0, 1)), $urandom);
         cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter CNT_W, default 32, width of the stall/flush event counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 RD1D, RD2D  in  XLEN  register-file read data for rs1/rs2 (x0 reads as 0).
REQ-006 Rs1D, Rs2D, RdD  in  5  source/destination register addresses from the decoded instruction.
REQ-007 ImmExtD, PCD, PCPlus4D  in  XLEN  extended immediate, instruction PC, PC+4.
REQ-008 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1  decoded control bits.
REQ-009 ResultSrcD  in  2  result select; 2'b01 = load.
REQ-010 ALUControlD  in  3  ALU operation.
REQ-011 PCSrcE  in  1  taken branch/jump resolved in Execute.
REQ-012 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  registered copies.
REQ-013 Rs1E, Rs2E, RdE  out  5; RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE  out  1; ResultSrcE  out  2; ALUControlE  out  3.
REQ-014 StallF, StallD, FlushD  out  1  hazard controls to fetch and IF/ID register.
REQ-015 StallCnt, FlushCnt  out  CNT_W  event counters.

Function
REQ-016 The block SHALL register all D-side inputs into E-side outputs with one cycle latency.
REQ-017 lwStall SHALL be combinational: ResultSrcE==2'b01 AND ValidE AND RdE!=0 AND (Rs1D==RdE OR Rs2D==RdE).
REQ-018 StallF and StallD SHALL equal lwStall; FlushD SHALL equal PCSrcE.
REQ-019 FlushE SHALL be internal, equal to lwStall OR PCSrcE.
REQ-020 On FlushE, the stage SHALL load a bubble: ValidE=0, RegWriteE=MemWriteE=JumpE=BranchE=0, ResultSrcE=0, RdE=0; datapath fields MAY hold any value.
REQ-021 Without FlushE, the stage SHALL load D inputs and ValidE=1.
REQ-022 The stage SHALL never hold (no stall of E); a load-use stall is resolved by one bubble, so lwStall lasts exactly one cycle per hazard.
REQ-023 PCSrcE and lwStall in the same cycle SHALL produce one bubble; StallF/StallD still assert; FlushD still asserts.
REQ-024 StallCnt SHALL increment by 1 each cycle lwStall=1; FlushCnt each cycle PCSrcE=1; both wrap modulo 2^CNT_W.
REQ-025 Rs1D==Rs2D==RdE SHALL raise a single stall (not two).
REQ-026 A load with RdE==0 SHALL raise no stall.

Reset
REQ-027 While rst=1 at a rising edge, all E outputs and both counters SHALL become 0 (ValidE=0, equivalent to a bubble).
REQ-028 Reset SHALL take priority over flush and load; outputs are defined from the first edge with rst=1.
REQ-029 StallF/StallD SHALL be 0 in the cycle after reset (ValidE=0).

Structure
REQ-030 Control bundle widths, ResultSrc encodings (ALU=00, LOAD=01, PC4=10) and the bubble value SHALL live in a shared pipeline package.
REQ-031 Load-use detection SHALL be a sub-module hazard_detect (combinational); the register bank and counters remain in id_ex_stage.

Verification
REQ-032 rst=1 for 2 cycles with nonzero inputs -> all E outputs, StallCnt, FlushCnt = 0.
REQ-033 ADD x5 then next instruction RD1D=0x1234, RdD=7, RegWriteD=1 -> next cycle RD1E=0x1234, RdE=7, ValidE=1, no stall.
REQ-034 lw x5 in E (ResultSrcE=01, RdE=5), Rs2D=5 -> StallF=StallD=1 that cycle; next cycle ValidE=0, RegWriteE=0, StallCnt=1; following cycle stall deasserts.
REQ-035 lw x0 in E, Rs1D=0 -> no stall, StallCnt unchanged.
REQ-036 PCSrcE=1 -> FlushD=1; next cycle bubble, FlushCnt=1; PCSrcE with lwStall together -> one bubble, StallCnt and FlushCnt both +1.
REQ-037 Preload CNT_W=4 counter to 15 via 15 stall events, one more -> StallCnt=0.
